// File: rtl/mul_host_pkg.sv
// Shared types and constants for the multiplier host scheduler.
package mul_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_MUL,
    SEND,
    WAIT_TX
  } state_t;

  localparam logic CH_UART = 1'b0;
  localparam logic CH_SPI  = 1'b1;

  localparam int OP_W_DFLT = 8;
  localparam int NB        = OP_W_DFLT / 8;

  function automatic logic [1:0] ch_onehot(input logic ch);
    return (ch == CH_SPI) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mul_frame_assembler.sv
// Per-link operand frame builder: shifts A then B in MSB-first, holds the frame
// (pend) until the scheduler has returned the full result on that link.
module mul_frame_assembler #(
  parameter int OP_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_valid_i,
  input  logic [7:0]      rx_data_i,
  input  logic            clear_i,
  output logic [OP_W-1:0] a_o,
  output logic [OP_W-1:0] b_o,
  output logic            pend_o,
  output logic            overrun_o
);

  localparam int NBYTES = OP_W / 8;
  localparam int CW     = $clog2(2 * NBYTES + 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*OP_W-1:0] frame_q, frame_d;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;

  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    if (pend_q) begin
      // frame is owned by the scheduler; any new byte is lost
      if (rx_valid_i) ovr_d = 1'b1;
      if (clear_i) begin
        pend_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (rx_valid_i) begin
      frame_d = {frame_q[2*OP_W-9:0], rx_data_i};
      if (cnt_q == CW'(2 * NBYTES - 1)) begin
        pend_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      frame_q <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign a_o       = frame_q[2*OP_W-1:OP_W];
  assign b_o       = frame_q[OP_W-1:0];
  assign pend_o    = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/mul_host_scheduler.sv
// Round-robin host sharing one multiplier between the UART and SPI byte links.
//   state    | meaning
//   IDLE     | no owner; arbitrate between pending frames
//   ISSUE    | present operands of the owner, pulse mul_start
//   WAIT_MUL | wait for mul_done or timer terminal count
//   SEND     | launch the next result byte on the owner link
//   WAIT_TX  | wait for the owner link to finish that byte
module mul_host_scheduler
  import mul_host_pkg::*;
#(
  parameter int OP_W    = 8 * NB,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx_valid_i,
  input  logic [7:0]        uart_rx_data_i,
  input  logic              uart_tx_ready_i,
  output logic              uart_tx_start_o,
  output logic [7:0]        uart_tx_data_o,
  input  logic              spi_rx_valid_i,
  input  logic [7:0]        spi_rx_data_i,
  input  logic              spi_tx_done_i,
  output logic              spi_tx_load_o,
  output logic [7:0]        spi_tx_data_o,
  output logic              mul_start_o,
  output logic [OP_W-1:0]   mul_a_o,
  output logic [OP_W-1:0]   mul_b_o,
  input  logic              mul_done_i,
  input  logic [2*OP_W-1:0] mul_p_i,
  output logic [1:0]        grant_o,
  output logic              busy_o,
  output logic [1:0]        overrun_o,
  output logic              err_timeout_o
);

  localparam int NBYTES = OP_W / 8;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int IW     = (NBYTES > 1) ? $clog2(2 * NBYTES) : 1;

  logic [OP_W-1:0] a_u, b_u, a_s, b_s;
  logic            pend_u, pend_s, clr_u, clr_s;

  mul_frame_assembler #(.OP_W(OP_W)) u_asm_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid_i(uart_rx_valid_i),
    .rx_data_i (uart_rx_data_i),
    .clear_i   (clr_u),
    .a_o       (a_u),
    .b_o       (b_u),
    .pend_o    (pend_u),
    .overrun_o (overrun_o[CH_UART])
  );

  mul_frame_assembler #(.OP_W(OP_W)) u_asm_spi (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid_i(spi_rx_valid_i),
    .rx_data_i (spi_rx_data_i),
    .clear_i   (clr_s),
    .a_o       (a_s),
    .b_o       (b_s),
    .pend_o    (pend_s),
    .overrun_o (overrun_o[CH_SPI])
  );

  state_t            state_q, state_d;
  logic              ch_q, ch_d, last_q, last_d, first_q, first_d;
  logic [1:0]        grant_q, grant_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [2*OP_W-1:0] res_q, res_d;
  logic              mstart_q, mstart_d, err_q, err_d;
  logic [OP_W-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic              ustart_q, ustart_d, sload_q, sload_d;
  logic [7:0]        udata_q, udata_d, sdata_q, sdata_d;
  logic              pick, tx_fin;
  logic [7:0]        tx_byte;

  assign tx_byte = res_q[2*OP_W-1 -: 8];

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    last_d   = last_q;
    first_d  = first_q;
    grant_d  = grant_q;
    tmr_d    = tmr_q;
    idx_d    = idx_q;
    res_d    = res_q;
    err_d    = err_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    udata_d  = udata_q;
    sdata_d  = sdata_q;
    mstart_d = 1'b0;
    ustart_d = 1'b0;
    sload_d  = 1'b0;
    clr_u    = 1'b0;
    clr_s    = 1'b0;
    pick     = CH_UART;
    tx_fin   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_u || pend_s) begin
          if (pend_u && pend_s) pick = ~last_q;
          else                  pick = pend_s ? CH_SPI : CH_UART;
          ch_d    = pick;
          last_d  = pick;
          grant_d = ch_onehot(pick);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ma_d     = (ch_q == CH_SPI) ? a_s : a_u;
        mb_d     = (ch_q == CH_SPI) ? b_s : b_u;
        mstart_d = 1'b1;
        tmr_d    = TW'(TIMEOUT - 1);
        state_d  = WAIT_MUL;
      end
      WAIT_MUL: begin
        if (mul_done_i) begin
          res_d   = mul_p_i;
          idx_d   = '0;
          state_d = SEND;
        end else if (tmr_q == '0) begin
          res_d   = '1;
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      SEND: begin
        if (ch_q == CH_SPI) begin
          sload_d = 1'b1;
          sdata_d = tx_byte;
          res_d   = {res_q[2*OP_W-9:0], 8'h00};
          state_d = WAIT_TX;
        end else if (uart_tx_ready_i) begin
          ustart_d = 1'b1;
          udata_d  = tx_byte;
          res_d    = {res_q[2*OP_W-9:0], 8'h00};
          first_d  = 1'b1;
          state_d  = WAIT_TX;
        end
      end
      WAIT_TX: begin
        // UART ready may still read high in the cycle right after start
        if (ch_q == CH_SPI)  tx_fin = spi_tx_done_i;
        else if (first_q)    first_d = 1'b0;
        else                 tx_fin = uart_tx_ready_i;
        if (tx_fin) begin
          if (idx_q == IW'(2 * NBYTES - 1)) begin
            clr_u   = (ch_q == CH_UART);
            clr_s   = (ch_q == CH_SPI);
            grant_d = 2'b00;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= CH_UART;
      last_q   <= CH_SPI;
      first_q  <= 1'b0;
      grant_q  <= 2'b00;
      tmr_q    <= '0;
      idx_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      mstart_q <= 1'b0;
      ustart_q <= 1'b0;
      udata_q  <= '0;
      sload_q  <= 1'b0;
      sdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      last_q   <= last_d;
      first_q  <= first_d;
      grant_q  <= grant_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      err_q    <= err_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      mstart_q <= mstart_d;
      ustart_q <= ustart_d;
      udata_q  <= udata_d;
      sload_q  <= sload_d;
      sdata_q  <= sdata_d;
    end
  end

  assign uart_tx_start_o = ustart_q;
  assign uart_tx_data_o  = udata_q;
  assign spi_tx_load_o   = sload_q;
  assign spi_tx_data_o   = sdata_q;
  assign mul_start_o     = mstart_q;
  assign mul_a_o         = ma_q;
  assign mul_b_o         = mb_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q != IDLE);
  assign err_timeout_o   = err_q;

endmodule

// File: tb/tb_mul_host_scheduler.sv
// Self-checking bench: link/multiplier models plus a {link,byte} scoreboard of returned results.
module tb_mul_host_scheduler;

  localparam int OP_W = 8;
  localparam int NBY  = OP_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              uart_rx_valid = 1'b0;
  logic [7:0]        uart_rx_data = '0;
  logic              uart_tx_ready = 1'b1;
  logic              uart_tx_start_o;
  logic [7:0]        uart_tx_data_o;
  logic              spi_rx_valid = 1'b0;
  logic [7:0]        spi_rx_data = '0;
  logic              spi_tx_done = 1'b0;
  logic              spi_tx_load_o;
  logic [7:0]        spi_tx_data_o;
  logic              mul_start_o;
  logic [OP_W-1:0]   mul_a_o, mul_b_o;
  logic              mul_done = 1'b0;
  logic [2*OP_W-1:0] mul_p = '0;
  logic [1:0]        grant_o;
  logic              busy_o;
  logic [1:0]        overrun_o;
  logic              err_timeout_o;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  bit         mul_en = 1'b1;

  always #5 clk = ~clk;

  mul_host_scheduler #(.OP_W(OP_W), .TIMEOUT(255)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_rx_valid_i(uart_rx_valid),
    .uart_rx_data_i (uart_rx_data),
    .uart_tx_ready_i(uart_tx_ready),
    .uart_tx_start_o(uart_tx_start_o),
    .uart_tx_data_o (uart_tx_data_o),
    .spi_rx_valid_i (spi_rx_valid),
    .spi_rx_data_i  (spi_rx_data),
    .spi_tx_done_i  (spi_tx_done),
    .spi_tx_load_o  (spi_tx_load_o),
    .spi_tx_data_o  (spi_tx_data_o),
    .mul_start_o    (mul_start_o),
    .mul_a_o        (mul_a_o),
    .mul_b_o        (mul_b_o),
    .mul_done_i     (mul_done),
    .mul_p_i        (mul_p),
    .grant_o        (grant_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .err_timeout_o  (err_timeout_o)
  );

  // multiplier: product presented 3 cycles after the start pulse
  initial begin : mul_model
    logic [OP_W-1:0] a, b;
    forever begin
      @(posedge clk); #1;
      if (mul_start_o && mul_en) begin
        a = mul_a_o;
        b = mul_b_o;
        repeat (2) @(posedge clk);
        #1;
        mul_done = 1'b1;
        mul_p    = (2*OP_W)'(a) * (2*OP_W)'(b);
        @(posedge clk); #1;
        mul_done = 1'b0;
      end
    end
  end

  initial begin : uart_model
    forever begin
      @(posedge clk); #1;
      if (uart_tx_start_o) begin
        uart_tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        uart_tx_ready = 1'b1;
      end
    end
  end

  initial begin : spi_model
    forever begin
      @(posedge clk); #1;
      if (spi_tx_load_o) begin
        repeat (2) @(posedge clk);
        #1;
        spi_tx_done = 1'b1;
        @(posedge clk); #1;
        spi_tx_done = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      if (uart_tx_start_o) obs_q.push_back({1'b0, uart_tx_data_o});
      if (spi_tx_load_o)   obs_q.push_back({1'b1, spi_tx_data_o});
    end
  end

  task automatic send_pair(input logic uv, input logic [7:0] ud,
                           input logic sv, input logic [7:0] sd);
    uart_rx_valid = uv;
    uart_rx_data  = ud;
    spi_rx_valid  = sv;
    spi_rx_data   = sd;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
    spi_rx_valid  = 1'b0;
  endtask

  task automatic push_exp(input logic link, input logic [2*OP_W-1:0] p);
    for (int i = 2*NBY-1; i >= 0; i--) exp_q.push_back({link, p[i*8 +: 8]});
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (obs_q.size() >= exp_q.size() && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({uart_tx_start_o, uart_tx_data_o, spi_tx_load_o, spi_tx_data_o, mul_start_o, mul_a_o,
         mul_b_o, grant_o, busy_o, overrun_o, err_timeout_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: some output nonzero during reset (grant=%b busy=%b)", grant_o, busy_o);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({grant_o, busy_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle: grant=%b busy=%b, need 00/0", grant_o, busy_o);
    end
  endtask

  task automatic test_uart_basic();
    bit ok;
    logic [8:0] e, o;
    send_pair(1'b1, 8'h0C, 1'b0, 8'h00);
    send_pair(1'b1, 8'h0B, 1'b0, 8'h00);
    push_exp(1'b0, 16'h0084);
    n_cmp++;
    if (grant_o !== 2'b00) begin
      n_err++;
      $display("FAIL uart_grant_early: grant=%b in pend-rise cycle, need 00", grant_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({grant_o, busy_o, mul_start_o} !== 4'b0110) begin
      n_err++;
      $display("FAIL uart_grant: grant/busy/start=%b, need 0110", {grant_o, busy_o, mul_start_o});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({mul_start_o, mul_a_o, mul_b_o} !== {1'b1, 8'h0C, 8'h0B}) begin
      n_err++;
      $display("FAIL uart_issue: start=%b a=%h b=%h, need 1/0c/0b", mul_start_o, mul_a_o, mul_b_o);
    end
    wait_done(300, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL uart_count: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL uart_byte: got %h, need %h", o, e);
      end
    end
    n_cmp++;
    if (grant_o !== 2'b00) begin
      n_err++;
      $display("FAIL uart_grant_release: grant=%b, need 00", grant_o);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_spi_basic();
    bit ok;
    logic [8:0] e, o;
    send_pair(1'b0, 8'h00, 1'b1, 8'hFF);
    send_pair(1'b0, 8'h00, 1'b1, 8'hFF);
    push_exp(1'b1, 16'hFE01);
    @(posedge clk); #1;
    n_cmp++;
    if (grant_o !== 2'b10) begin
      n_err++;
      $display("FAIL spi_grant: grant=%b, need 10", grant_o);
    end
    wait_done(300, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL spi_count: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL spi_byte: got %h, need %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // last owner is SPI here, so the first tie goes to UART; a lone UART frame
  // then leaves UART as last owner, so the next tie goes to SPI
  task automatic test_tie();
    bit ok;
    logic [8:0] e, o;
    send_pair(1'b1, 8'h21, 1'b1, 8'h10);
    send_pair(1'b1, 8'h03, 1'b1, 8'h0F);
    push_exp(1'b0, 16'h0063);
    push_exp(1'b1, 16'h00F0);
    wait_done(600, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL tie1_count: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL tie1_byte: got %h, need %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    send_pair(1'b1, 8'h02, 1'b0, 8'h00);
    send_pair(1'b1, 8'h02, 1'b0, 8'h00);
    push_exp(1'b0, 16'h0004);
    wait_done(300, ok);
    send_pair(1'b1, 8'h11, 1'b1, 8'h80);
    send_pair(1'b1, 8'h11, 1'b1, 8'h02);
    push_exp(1'b1, 16'h0100);
    push_exp(1'b0, 16'h0121);
    wait_done(600, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL tie2_count: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL tie2_byte: got %h, need %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_overrun();
    bit ok;
    logic [8:0] e, o;
    n_cmp++;
    if (overrun_o !== 2'b00) begin
      n_err++;
      $display("FAIL overrun_pre: overrun=%b, need 00", overrun_o);
    end
    send_pair(1'b1, 8'h03, 1'b0, 8'h00);
    send_pair(1'b1, 8'h05, 1'b0, 8'h00);
    send_pair(1'b1, 8'h77, 1'b0, 8'h00);
    push_exp(1'b0, 16'h000F);
    wait_done(300, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL overrun_count: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL overrun_byte: got %h, need %h", o, e);
      end
    end
    n_cmp++;
    if (overrun_o !== 2'b01) begin
      n_err++;
      $display("FAIL overrun_flag: overrun=%b, need 01", overrun_o);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    int cnt;
    logic [8:0] e, o;
    mul_en = 1'b0;
    send_pair(1'b0, 8'h00, 1'b1, 8'h12);
    send_pair(1'b0, 8'h00, 1'b1, 8'h34);
    push_exp(1'b1, 16'hFFFF);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = mul_start_o;
    end
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (spi_tx_load_o) break;
    end
    // timer expires on the 255th WAIT_MUL cycle, SEND adds one more
    n_cmp++;
    if (!seen || cnt != 256) begin
      n_err++;
      $display("FAIL timeout_latency: start seen=%0d, start-to-load %0d cycles, need 256", seen, cnt);
    end
    wait_done(300, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL timeout_count: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL timeout_byte: got %h, need %h", o, e);
      end
    end
    n_cmp++;
    if (err_timeout_o !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_flag: err_timeout=%b, need 1", err_timeout_o);
    end
    exp_q.delete();
    obs_q.delete();
    mul_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    logic [8:0] e, o;
    send_pair(1'b0, 8'h00, 1'b1, 8'h07);
    send_pair(1'b0, 8'h00, 1'b1, 8'h06);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      seen = spi_tx_load_o;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL rstmid_load: spi_tx_load not seen within 50 cycles");
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({uart_tx_start_o, uart_tx_data_o, spi_tx_load_o, spi_tx_data_o, mul_start_o, mul_a_o,
         mul_b_o, grant_o, busy_o, overrun_o, err_timeout_o} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs: nonzero (grant=%b busy=%b ovr=%b err=%b)",
               grant_o, busy_o, overrun_o, err_timeout_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() != 0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_quiet: %0d pulses after reset, busy=%b, need 0/0", obs_q.size(), busy_o);
    end
    send_pair(1'b1, 8'h10, 1'b0, 8'h00);
    send_pair(1'b1, 8'h10, 1'b0, 8'h00);
    push_exp(1'b0, 16'h0100);
    wait_done(300, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rstmid_count: got %0d bytes, need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL rstmid_byte: got %h, need %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_uart_basic();
    test_spi_basic();
    test_tie();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
